// File: rtl/time_set_ctrl.sv
// time_set_ctrl: time-of-day counter with front-panel set controller.
//   Counts hh:mm:ss from a 1 Hz tick; key_mode cycles RUN -> SET_H -> SET_M
//   -> SET_S -> RUN, and key_inc increments the selected field (no carry).
//   While a field is being set it blinks through the blank code.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tick      1-cycle pulse per second
//   key_mode  mode button level (debounced, synchronized)
//   key_inc   increment button level (debounced, synchronized)
//   sec       seconds 0..59      (display num0)
//   min       minutes 0..59      (display num1)
//   hour      hours 0..HOURS-1   (display num2)
//   blank     field-blank code: 00 none, 01 sec, 10 min, 11 hour
//   setting   high in any SET state (clock paused)
module time_set_ctrl #(
   parameter int unsigned BLINK_DIV = 25_000_000,
   parameter int unsigned HOURS     = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [6:0] sec,
   output logic [6:0] min,
   output logic [6:0] hour,
   output logic [1:0] blank,
   output logic       setting
);

   localparam int unsigned     CW         = $clog2(BLINK_DIV);
   localparam logic [CW-1:0]   BLINK_LAST = CW'(BLINK_DIV - 1);
   localparam logic [6:0]      HOUR_LAST  = 7'(HOURS - 1);
   localparam logic [6:0]      MS_LAST    = 7'd59;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      SET_H = 2'b01,
      SET_M = 2'b10,
      SET_S = 2'b11
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          key_mode_q;
   logic          key_inc_q;
   logic          mode_ev;
   logic          inc_ev;
   logic          inc_acc;
   logic [CW-1:0] blink_cnt;
   logic          blink_phase;
   logic [1:0]    field_code;

   // Rising-edge detection against last cycle's key levels.
   assign mode_ev = key_mode & ~key_mode_q;
   assign inc_ev  = key_inc & ~key_inc_q;
   // An increment is only accepted while setting, and mode wins a tie.
   assign inc_acc = inc_ev & ~mode_ev & (state != RUN);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (mode_ev) begin
         case (state)
            RUN:     state_nxt = SET_H;
            SET_H:   state_nxt = SET_M;
            SET_M:   state_nxt = SET_S;
            SET_S:   state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   // Output decode (from registered state and blink phase only)
   always_comb begin
      setting = (state != RUN);
      case (state)
         SET_H:   field_code = 2'b11;
         SET_M:   field_code = 2'b10;
         SET_S:   field_code = 2'b01;
         default: field_code = 2'b00;
      endcase
      blank = (setting && blink_phase) ? field_code : 2'b00;
   end

   // Key history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_mode_q <= 1'b0;
         key_inc_q  <= 1'b0;
      end else begin
         key_mode_q <= key_mode;
         key_inc_q  <= key_inc;
      end
   end

   // Blink timer: restarts on any keypress so the field is shown at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (mode_ev || inc_acc) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + CW'(1);
      end
   end

   // Time-of-day fields. Ticks use the current state, so a tick coinciding
   // with the mode press out of RUN still counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec  <= '0;
         min  <= '0;
         hour <= '0;
      end else if (state == RUN && tick) begin
         if (sec == MS_LAST) begin
            sec <= '0;
            if (min == MS_LAST) begin
               min  <= '0;
               hour <= (hour == HOUR_LAST) ? '0 : hour + 7'd1;
            end else begin
               min <= min + 7'd1;
            end
         end else begin
            sec <= sec + 7'd1;
         end
      end else if (inc_acc) begin
         case (state)
            SET_H:   hour <= (hour == HOUR_LAST) ? '0 : hour + 7'd1;
            SET_M:   min  <= (min == MS_LAST)    ? '0 : min + 7'd1;
            SET_S:   sec  <= (sec == MS_LAST)    ? '0 : sec + 7'd1;
            default: ;
         endcase
      end
   end

endmodule
